// File: rtl/dram_pkg.sv
// Shared DRAM command states, timing constants and the per-state window lookup.
package dram_pkg;

    localparam int TIMER_W = 16;

    localparam int tRCD   = 4;
    localparam int tRL    = 6;
    localparam int tWL    = 4;
    localparam int tBURST = 4;
    localparam int tWR    = 5;
    localparam int tRP    = 4;
    localparam int tRFC   = 20;
    localparam int tREFI  = 100;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ACTIVATE,
        READ,
        WRITE,
        PRECHARGE,
        REFRESH,
        SELF_REFRESH
    } dram_state_t;

    // Zero marks an untimed state.
    function automatic logic [TIMER_W-1:0] window_of(input dram_state_t s);
        case (s)
            ACTIVATE:  return TIMER_W'(tRCD);
            READ:      return TIMER_W'(tRL + tBURST);
            WRITE:     return TIMER_W'(tWL + tBURST + tWR);
            PRECHARGE: return TIMER_W'(tRP);
            REFRESH:   return TIMER_W'(tRFC);
            default:   return '0;
        endcase
    endfunction

endpackage

// File: rtl/dram_timer.sv
// Loadable down-counter saturating at zero; load takes effect next cycle.
// No flow control: counts every cycle unless reloaded.
module dram_timer
    import dram_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    output logic [TIMER_W-1:0] value,
    output logic               expired
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - TIMER_W'(1);
        end
    end

    assign expired = (value == '0);

endmodule

// File: rtl/dram_timing_ctrl.sv
// Tracks DRAM command timing windows and the refresh interval.
// Done flags rise T cycles after state entry and drop the cycle the state is left.
module dram_timing_ctrl
    import dram_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  dram_state_t cmd_state,
    input  logic        init_done,
    output logic        tACT_done,
    output logic        tRD_done,
    output logic        tWR_done,
    output logic        tPRE_done,
    output logic        tREF_done,
    output logic        rf_req
);

    dram_state_t        prev_state;
    logic               primed;
    logic               armed;
    logic               done_q;
    logic               done_next;
    logic [TIMER_W-1:0] window;
    logic [TIMER_W-1:0] load_value;
    logic [TIMER_W-1:0] win_value;
    logic               win_expired;
    logic [TIMER_W-1:0] rcnt;
    logic               ref_expire;
    logic               timed;
    logic               stay;
    logic               entry;
    logic               load;
    logic               held;

    // The first cycle after reset has no trustworthy history, so it never counts as an entry.
    always_comb begin
        window     = window_of(cmd_state);
        load_value = window - TIMER_W'(1);
        timed      = (window != '0);
        stay       = (cmd_state == prev_state);
        entry      = primed && !stay;
        load       = entry && timed;
        held       = stay && done_q;
        ref_expire = init_done && (rcnt == TIMER_W'(tREFI - 1));
        done_next  = 1'b0;
        if (load) begin
            done_next = (window == TIMER_W'(1));
        end else if (timed && armed && stay) begin
            done_next = win_expired || (win_value == TIMER_W'(1));
        end
    end

    dram_timer u_timer (
        .clk        (CLK),
        .rst_n      (nRST),
        .load       (load),
        .load_value (load_value),
        .value      (win_value),
        .expired    (win_expired)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            prev_state <= IDLE;
            primed     <= 1'b0;
            armed      <= 1'b0;
            done_q     <= 1'b0;
            rcnt       <= '0;
            rf_req     <= 1'b0;
        end else begin
            prev_state <= cmd_state;
            primed     <= 1'b1;
            armed      <= load || (armed && stay);
            done_q     <= done_next;
            if (!init_done || ref_expire) begin
                rcnt <= '0;
            end else begin
                rcnt <= rcnt + TIMER_W'(1);
            end
            // A new expiry wins over a simultaneous REFRESH entry.
            if (ref_expire) begin
                rf_req <= 1'b1;
            end else if (entry && cmd_state == REFRESH) begin
                rf_req <= 1'b0;
            end
        end
    end

    always_comb begin
        tACT_done = 1'b0;
        tRD_done  = 1'b0;
        tWR_done  = 1'b0;
        tPRE_done = 1'b0;
        tREF_done = 1'b0;
        if (held) begin
            case (cmd_state)
                ACTIVATE:  tACT_done = 1'b1;
                READ:      tRD_done  = 1'b1;
                WRITE:     tWR_done  = 1'b1;
                PRECHARGE: tPRE_done = 1'b1;
                REFRESH:   tREF_done = 1'b1;
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_timing_ctrl.sv
// Bench for dram_timing_ctrl: directed scenarios plus random state sequences against a cycle-count model.
module tb_dram_timing_ctrl;
    import dram_pkg::*;

    logic        CLK;
    logic        nRST;
    dram_state_t cmd_state;
    logic        init_done;
    logic        tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done, rf_req;

    dram_timing_ctrl dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .cmd_state (cmd_state),
        .init_done (init_done),
        .tACT_done (tACT_done),
        .tRD_done  (tRD_done),
        .tWR_done  (tWR_done),
        .tPRE_done (tPRE_done),
        .tREF_done (tREF_done),
        .rf_req    (rf_req)
    );

    localparam int REFI = 100;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: remembers the cycle of the last real entry and counts init cycles.
    dram_state_t m_prev      = IDLE;
    bit          m_primed    = 0;
    int          m_entry_cyc = -1;
    bit          m_rf        = 0;
    int          m_n         = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic int win(input dram_state_t s);
        case (s)
            ACTIVATE:  return 4;
            READ:      return 10;
            WRITE:     return 13;
            PRECHARGE: return 4;
            REFRESH:   return 20;
            default:   return 0;
        endcase
    endfunction

    function automatic int done_bit(input dram_state_t s);
        case (s)
            ACTIVATE:  return 0;
            READ:      return 1;
            WRITE:     return 2;
            PRECHARGE: return 3;
            default:   return 4;
        endcase
    endfunction

    // Drives one cycle; returns observed {rf,ref,pre,wr,rd,act} and the model's expectation.
    task automatic step(input dram_state_t s, input logic init, input logic rst,
                        output logic [5:0] got, output logic [5:0] exp);
        bit entry;
        bit expire;
        int w;
        @(negedge CLK);
        cmd_state = s;
        init_done = init;
        nRST      = rst;
        #1;
        got   = {rf_req, tREF_done, tPRE_done, tWR_done, tRD_done, tACT_done};
        entry = m_primed && (s != m_prev);
        w     = win(s);
        exp   = '0;
        exp[5] = m_rf;
        if (!entry && s == m_prev && m_entry_cyc >= 0 && w > 0 && (cyc - m_entry_cyc) >= w)
            exp[done_bit(s)] = 1'b1;
        @(posedge CLK);
        if (!rst) begin
            m_primed    = 0;
            m_entry_cyc = -1;
            m_rf        = 0;
            m_n         = 0;
            m_prev      = IDLE;
        end else begin
            expire = init && (((m_n + 1) % REFI) == 0);
            m_n    = init ? m_n + 1 : 0;
            if (expire) m_rf = 1;
            else if (entry && s == REFRESH) m_rf = 0;
            if (entry) m_entry_cyc = cyc;
            m_prev   = s;
            m_primed = 1;
        end
        cyc++;
    endtask

    task automatic test_reset();
        logic [5:0] g, e;
        for (int k = 0; k < 3; k++) step(ACTIVATE, 1'b1, 1'b0, g, e);
        step(IDLE, 1'b0, 1'b1, g, e);
        n_tests++;
        if (g !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs cyc=%0d got=%b exp=%b", cyc, g, 6'b0);
        end
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL reset_model cyc=%0d got=%b exp=%b", cyc, g, e);
        end
    endtask

    task automatic test_activate();
        logic [5:0] g, e;
        step(IDLE, 1'b0, 1'b0, g, e);
        step(IDLE, 1'b0, 1'b1, g, e);
        for (int k = 0; k < 8; k++) begin
            step(ACTIVATE, 1'b0, 1'b1, g, e);
            n_tests++;
            if (g[0] !== 1'(k >= 4)) begin
                n_fail++;
                $display("FAIL act_window k=%0d got=%b exp=%b", k, g[0], 1'(k >= 4));
            end
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL act_model cyc=%0d got=%b exp=%b", cyc, g, e);
            end
        end
        step(IDLE, 1'b0, 1'b1, g, e);
        n_tests++;
        if (g !== 6'b0) begin
            n_fail++;
            $display("FAIL act_exit cyc=%0d got=%b exp=%b", cyc, g, 6'b0);
        end
    endtask

    task automatic test_read_write();
        logic [5:0] g, e;
        step(IDLE, 1'b0, 1'b1, g, e);
        for (int k = 0; k < 16; k++) begin
            step(WRITE, 1'b0, 1'b1, g, e);
            n_tests++;
            if (g[2] !== 1'(k >= 13) || g !== e) begin
                n_fail++;
                $display("FAIL wr_window k=%0d got=%b exp_wr=%b model=%b", k, g, 1'(k >= 13), e);
            end
        end
        // Direct WRITE->READ: READ counts from its own entry.
        for (int k = 0; k < 12; k++) begin
            step(READ, 1'b0, 1'b1, g, e);
            n_tests++;
            if (g[1] !== 1'(k >= 10) || g[2] !== 1'b0 || g !== e) begin
                n_fail++;
                $display("FAIL rd_window k=%0d got=%b exp_rd=%b model=%b", k, g, 1'(k >= 10), e);
            end
        end
    endtask

    task automatic test_abort();
        logic [5:0] g, e;
        step(IDLE, 1'b0, 1'b1, g, e);
        for (int k = 0; k < 2; k++) begin
            step(PRECHARGE, 1'b0, 1'b1, g, e);
            n_tests++;
            if (g[3] !== 1'b0) begin
                n_fail++;
                $display("FAIL pre_abort k=%0d got=%b exp=0", k, g[3]);
            end
        end
        for (int k = 0; k < 6; k++) begin
            step(ACTIVATE, 1'b0, 1'b1, g, e);
            n_tests++;
            if (g[3] !== 1'b0 || g[0] !== 1'(k >= 4) || g !== e) begin
                n_fail++;
                $display("FAIL pre_then_act k=%0d got=%b exp_act=%b model=%b", k, g, 1'(k >= 4), e);
            end
        end
    endtask

    task automatic test_refresh();
        logic [5:0] g, e;
        dram_state_t s;
        step(IDLE, 1'b0, 1'b0, g, e);
        step(IDLE, 1'b0, 1'b1, g, e);
        for (int k = 0; k <= 280; k++) begin
            s = (k < 250) ? IDLE : REFRESH;
            step(s, 1'b1, 1'b1, g, e);
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL ref_model k=%0d got=%b exp=%b", k, g, e);
            end
            if (k == 99 || k == 100 || k == 250 || k == 251 || k == 269 || k == 270) begin
                n_tests++;
                if (g[5] !== 1'(k >= 100 && k <= 250) || g[4] !== 1'(k >= 270)) begin
                    n_fail++;
                    $display("FAIL ref_points k=%0d got_rf=%b got_ref=%b exp_rf=%b exp_ref=%b",
                             k, g[5], g[4], 1'(k >= 100 && k <= 250), 1'(k >= 270));
                end
            end
        end
    endtask

    task automatic test_reset_mid_window();
        logic [5:0] g, e;
        step(IDLE, 1'b1, 1'b1, g, e);
        step(ACTIVATE, 1'b1, 1'b1, g, e);
        step(ACTIVATE, 1'b1, 1'b1, g, e);
        step(ACTIVATE, 1'b1, 1'b0, g, e);
        for (int k = 0; k < 12; k++) begin
            step(ACTIVATE, 1'b0, 1'b1, g, e);
            n_tests++;
            if (g !== 6'b0 || g !== e) begin
                n_fail++;
                $display("FAIL reset_mid k=%0d got=%b exp=%b", k, g, 6'b0);
            end
        end
    endtask

    task automatic test_no_init();
        logic [5:0] g, e;
        int bad;
        bad = 0;
        for (int k = 0; k < 500; k++) begin
            step(dram_state_t'($urandom_range(0, 7)), 1'b0, 1'b1, g, e);
            if (g[5] !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL no_init_rf got=%0d_high_cycles exp=0", bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] g, e;
        dram_state_t s;
        logic init;
        int len;
        init = 1'b1;
        for (int seg = 0; seg < 120; seg++) begin
            s   = dram_state_t'($urandom_range(0, 7));
            len = $urandom_range(1, 24);
            if ($urandom_range(0, 9) == 0) init = ~init;
            if ($urandom_range(0, 29) == 0) step(s, init, 1'b0, g, e);
            for (int k = 0; k < len; k++) begin
                step(s, init, 1'b1, g, e);
                n_tests++;
                if (g !== e || $countones(g[4:0]) > 1) begin
                    n_fail++;
                    $display("FAIL random cyc=%0d state=%s got=%b exp=%b", cyc, s.name(), g, e);
                end
            end
        end
    endtask

    initial begin
        nRST      = 1'b0;
        cmd_state = IDLE;
        init_done = 1'b0;
        test_reset();
        test_activate();
        test_read_write();
        test_abort();
        test_refresh();
        test_reset_mid_window();
        test_no_init();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_timing_ctrl.md
DRAM_TIMING_CTRL -- requirements
Module: dram_timing_ctrl

Interface
REQ-001 SHALL have one clock, CLK; reset nRST is synchronous and active-low.
REQ-002 SHALL have port: CLK  in  1  system clock.
REQ-003 SHALL have port: nRST  in  1  synchronous active-low reset.
REQ-004 SHALL have port: cmd_state  in  dram_state_t  current command-FSM state.
REQ-005 SHALL have port: init_done  in  1  DRAM init sequence complete; enables refresh timing.
REQ-006 SHALL have ports tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done: each out, 1 bit, timing window of ACTIVATE/READ/WRITE/PRECHARGE/REFRESH elapsed.
REQ-007 SHALL have port: rf_req  out  1  refresh due.
REQ-008 SHALL take timing values from dram_pkg constants, not ports: tRCD, tRL, tWL, tBURST, tWR, tRP, tRFC, tREFI, all ≥ 1 cycle.

Function
REQ-009 SHALL register prev_state each cycle; "entry" into state X = cmd_state==X and prev_state!=X.
REQ-010 SHALL derive windows T: ACTIVATE=tRCD; READ=tRL+tBURST; WRITE=tWL+tBURST+tWR; PRECHARGE=tRP; REFRESH=tRFC.
REQ-011 SHALL load the shared window counter on entry into any timed state; the entry cycle is cycle 0.
REQ-012 SHALL assert the matching done output, registered, from cycle T after entry and hold it while cmd_state stays X.
REQ-013 SHALL deassert done in the first cycle cmd_state!=X; at most one done output high at any time.
REQ-014 SHALL abort the count with no done pulse when cmd_state leaves X before T.
REQ-015 SHALL treat a direct transition X->Y between timed states as exit from X and entry into Y in the same cycle; Y's count starts at cycle 0.
REQ-016 SHALL keep all done outputs low in IDLE and all untimed states.
REQ-017 SHALL hold the refresh-interval counter at 0 while init_done=0.
REQ-018 SHALL increment the refresh counter each cycle while init_done=1; on reaching tREFI-1 it wraps to 0 and sets rf_req.
REQ-019 SHALL hold rf_req high until entry into REFRESH, which clears it next cycle.
REQ-020 SHALL drop, with no queueing, a further expiry that occurs while rf_req is pending; rf_req stays 1.
REQ-021 SHALL give precedence to set on simultaneous expiry and REFRESH entry: rf_req stays 1.
REQ-022 SHALL size counters by dram_pkg constant TIMER_W=16; windows >2^16-1 are illegal.

Reset
REQ-023 SHALL, while nRST=0 at a CLK edge: set all done outputs and rf_req to 0, window and refresh counters to 0, prev_state to IDLE.
REQ-024 SHALL, on reset mid-window or mid-interval, discard the count; after release, timing restarts only on a new entry or on init_done.

Structure
REQ-025 SHALL keep dram_state_t, the timing constants and TIMER_W in dram_pkg.
REQ-026 SHALL implement the window count in one sub-module, dram_timer: loadable down-counter with load, value and expired outputs.
REQ-027 SHALL use no other sub-modules; refresh counter and done decode are local.

Verification (tRCD=4, tRP=4, tRL=6, tWL=4, tBURST=4, tWR=5, tRFC=20, tREFI=100)
REQ-028 SHALL test: IDLE->ACTIVATE held 8 cycles -> tACT_done=0 in cycles 0-3, 1 in cycles 4-7, 0 after exit.
REQ-029 SHALL test: WRITE entry held -> tWR_done first high at cycle 13; READ entry held -> tRD_done first high at cycle 10.
REQ-030 SHALL test: PRECHARGE left after 2 cycles, then ACTIVATE -> no tPRE_done pulse; tACT_done high at cycle 4 of ACTIVATE.
REQ-031 SHALL test: init_done=1 at cycle 0, no REFRESH entry -> rf_req=1 from cycle 100, still 1 at 250; REFRESH entry at 250 -> rf_req=0 at 251, tREF_done=1 at 270.
REQ-032 SHALL test: nRST=0 for 1 cycle at ACTIVATE cycle 2 -> all outputs 0; ACTIVATE held afterwards -> no tACT_done.
REQ-033 SHALL test: init_done=0 for 500 cycles -> rf_req=0 throughout.
